// File: rtl/lif_pkg.sv
// lif_pkg: shared constants, FSM state type and parity helper for the lif cell and its input loader.
//   NIB_W      : nibble width (fixed at 4, two nibbles per 8-bit beat)
//   NUM_IN_DEF : default neighbour nibble count per frame
//   state_t    : loader FSM states (LOAD, COMMIT)
//   even_par   : XOR reduction of a byte, used by the optional parity check
package lif_pkg;
    localparam int NIB_W      = 4;
    localparam int NUM_IN_DEF = 4;

    typedef enum logic {LOAD, COMMIT} state_t;

    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction
endpackage

// File: rtl/lif_in_loader.sv
// lif_in_loader: assembles 8-bit beats into NUM_IN nibbles and commits whole frames atomically to the cell inputs.
// Optional feature macro: LIF_IN_LOADER_PARITY_EN (adds din_par / par_err, drops frames with a bad beat).
// Ports:
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   din       : beat data, [3:0] even nibble, [7:4] odd nibble
//   din_valid : beat present
//   din_ready : loader accepts a beat this cycle (LOAD state)
//   sync_clr  : abort the partial frame / cancel a pending commit
//   nib_out   : committed nibbles, nibble k at [k*4 +: 4]
//   upd       : one-cycle pulse after nib_out changes
//   din_par   : (macro) even-parity bit for din
//   par_err   : (macro) sticky frame parity error
module lif_in_loader
    import lif_pkg::*;
#(
    parameter int NUM_IN = NUM_IN_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              din,
    input  logic                    din_valid,
    output logic                    din_ready,
    input  logic                    sync_clr,
    output logic [NUM_IN*NIB_W-1:0] nib_out,
    output logic                    upd
`ifdef LIF_IN_LOADER_PARITY_EN
    ,
    input  logic                    din_par,
    output logic                    par_err
`endif
);
    localparam int BEATS = NUM_IN / 2;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_t                    state, state_nx;
    logic [IDX_W-1:0]          idx;
    logic [NUM_IN*NIB_W-1:0]   shadow;
    logic                      accept, last, commit, ok;

    assign last = (idx == IDX_W'(BEATS - 1));

`ifdef LIF_IN_LOADER_PARITY_EN
    logic frame_bad;
    assign ok = !frame_bad;

    // frame_bad spans the whole frame including the COMMIT cycle, where it
    // decides between committing and flagging par_err.
    always_ff @(posedge clk) begin
        if (!rst_n || sync_clr) begin
            frame_bad <= 1'b0;
            par_err   <= 1'b0;
        end else if (state == COMMIT) begin
            frame_bad <= 1'b0;
            if (frame_bad) par_err <= 1'b1;
        end else if (accept && (even_par(din) ^ din_par)) begin
            frame_bad <= 1'b1;
        end
    end
`else
    assign ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        din_ready = (state == LOAD);
        accept    = din_valid && din_ready && !sync_clr;
        commit    = 1'b0;
        if (sync_clr) begin
            state_nx = LOAD;
        end else if (state == COMMIT) begin
            state_nx = LOAD;
            commit   = ok;
        end else if (accept && last) begin
            state_nx = COMMIT;
        end
    end

    // Shadow is never cleared: every frame rewrites all nibbles before its commit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx     <= '0;
            shadow  <= '0;
            nib_out <= '0;
            upd     <= 1'b0;
        end else begin
            upd <= commit;
            if (commit) nib_out <= shadow;
            if (sync_clr) begin
                idx <= '0;
            end else if (accept) begin
                shadow[8*int'(idx) +: 8] <= din;
                idx <= last ? '0 : idx + 1'b1;
            end
        end
    end
endmodule
